// File: rtl/alu_virtual_board_pkg.sv
// Shared types and constants for the DE10-Lite ALU virtual board.
package alu_virtual_board_pkg;

   localparam int ORIG_OPERAND_W   = 4;
   localparam int SELECT_W         = 3;
   localparam int DEBOUNCE_DEFAULT = 50000;

   typedef enum logic [SELECT_W-1:0] {
      OP_CLEAR = 3'd0,
      OP_AND   = 3'd1,
      OP_OR    = 3'd2,
      OP_ADD   = 3'd3,
      OP_SUB   = 3'd4,
      OP_XOR   = 3'd5,
      OP_SHL   = 3'd6,
      OP_SHR   = 3'd7
   } e_operation;

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      LOAD_OP = 2'd2,
      ISSUE   = 2'd3
   } e_loader_state;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Valid/ready transaction bus from the operand loader to the ALU.
interface alu_operand_loader_if;
   import alu_virtual_board_pkg::*;

   logic                      alu_valid;
   logic                      alu_ready;
   logic [ORIG_OPERAND_W-1:0] op_a;
   logic [ORIG_OPERAND_W-1:0] op_b;
   e_operation                op_sel;

   modport master (output alu_valid, output op_a, output op_b, output op_sel, input alu_ready);
   modport slave  (input alu_valid, input op_a, input op_b, input op_sel, output alu_ready);

endinterface

// File: rtl/alu_operand_loader_key_debounce.sv
// Synchronizer plus stability counter for one active-low key; emits a
// one-cycle pulse on each accepted press (1->0), never on release.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_out;
   logic                   level;
   logic [CNT_W-1:0]       cnt;

   assign sync_out = sync[SYNC_STAGES-1];

   // Counter only advances while the synchronized level disagrees with the
   // accepted one; any return to agreement restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '1;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], key_n};
         press <= 1'b0;
         if (sync_out == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync_out;
            cnt   <= '0;
            press <= level & ~sync_out;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_operand_loader.sv
// Key-driven capture of operand A, operand B and operation, offered to the
// ALU as one valid/ready transaction.
module alu_operand_loader
   import alu_virtual_board_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int SYNC_STAGES     = 2,
   parameter int COUNT_W         = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      key_enter_n,
   input  logic                      key_cancel_n,
   input  logic [ORIG_OPERAND_W-1:0] sw_data,
   input  logic [SELECT_W-1:0]       sw_sel,
   alu_operand_loader_if.master      alu,
   output logic [3:0]                stage_led,
   output logic [COUNT_W-1:0]        op_count
);

   logic [SYNC_STAGES-1:0][ORIG_OPERAND_W-1:0] data_sync;
   logic [SYNC_STAGES-1:0][SELECT_W-1:0]       sel_sync;
   logic          enter_evt, cancel_evt;
   e_loader_state state, state_nxt;
   logic          cap_a, cap_b, cap_op, xfer;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_enter (
      .clk(clk), .rst_n(rst_n), .key_n(key_enter_n), .press(enter_evt)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_cancel (
      .clk(clk), .rst_n(rst_n), .key_n(key_cancel_n), .press(cancel_evt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_sync <= '0;
         sel_sync  <= '0;
      end else begin
         data_sync[0] <= sw_data;
         sel_sync[0]  <= sw_sel;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            data_sync[i] <= data_sync[i-1];
            sel_sync[i]  <= sel_sync[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LOAD_A;
      else        state <= state_nxt;
   end

   // Cancel outranks enter in LOAD_B/LOAD_OP; ISSUE ignores both keys.
   always_comb begin
      state_nxt = state;
      cap_a     = 1'b0;
      cap_b     = 1'b0;
      cap_op    = 1'b0;
      xfer      = 1'b0;
      unique case (state)
         LOAD_A: if (enter_evt) begin
            cap_a     = 1'b1;
            state_nxt = LOAD_B;
         end
         LOAD_B: if (cancel_evt) begin
            state_nxt = LOAD_A;
         end else if (enter_evt) begin
            cap_b     = 1'b1;
            state_nxt = LOAD_OP;
         end
         LOAD_OP: if (cancel_evt) begin
            state_nxt = LOAD_A;
         end else if (enter_evt) begin
            cap_op    = 1'b1;
            state_nxt = ISSUE;
         end
         ISSUE: if (alu.alu_valid && alu.alu_ready) begin
            xfer      = 1'b1;
            state_nxt = LOAD_A;
         end
         default: state_nxt = LOAD_A;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu.alu_valid <= 1'b0;
         alu.op_a      <= '0;
         alu.op_b      <= '0;
         alu.op_sel    <= OP_CLEAR;
         op_count      <= '0;
      end else begin
         if (cap_a) alu.op_a <= data_sync[SYNC_STAGES-1];
         if (cap_b) alu.op_b <= data_sync[SYNC_STAGES-1];
         if (cap_op) begin
            alu.op_sel    <= e_operation'(sel_sync[SYNC_STAGES-1]);
            alu.alu_valid <= 1'b1;
         end
         if (xfer) begin
            alu.alu_valid <= 1'b0;
            op_count      <= op_count + 1'b1;
         end
      end
   end

   always_comb stage_led = 4'(4'b0001 << state);

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Upstream input stage of the DE10-Lite ALU virtual board.
- Turns raw push-button and slide-switch activity into one clean, registered ALU transaction: operand A, operand B and an operation code (e_operation).
- A debounced ENTER key steps a capture state machine; the completed triple is offered downstream with a valid/ready handshake.
- A CANCEL key aborts an entry in progress.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronized cycles before a key level is accepted (1 ms at 50 MHz); minimum 2.
- SYNC_STAGES, 2, flip-flop stages on every asynchronous board input; minimum 2.
- COUNT_W, 8, width of the issued-transaction counter.

Ports:
- clk  in  1  board clock
- rst_n  in  1  asynchronous active-low reset
- key_enter_n  in  1  raw ENTER push-button, active-low, asynchronous
- key_cancel_n  in  1  raw CANCEL push-button, active-low, asynchronous
- sw_data  in  ORIG_OPERAND_W  raw operand switches, asynchronous
- sw_sel  in  SELECT_W  raw operation switches, asynchronous
- alu_ready  in  1  downstream ALU can accept a transaction
- alu_valid  out  1  transaction offered
- op_a  out  ORIG_OPERAND_W  registered operand A
- op_b  out  ORIG_OPERAND_W  registered operand B
- op_sel  out  SELECT_W  registered operation (e_operation)
- stage_led  out  4  one-hot current state, bit0 = LOAD_A … bit3 = ISSUE
- op_count  out  COUNT_W  completed transactions, wraps

Behaviour:
- Reset: clk and rst_n are fixed as one clock with an asynchronous active-low reset. On assertion, independent of clk, every output and internal register clears: alu_valid=0, op_a=0, op_b=0, op_sel=OP_CLEAR, op_count=0, state=LOAD_A, stage_led=4'b0001. Synchronizers and debouncers clear to the "released" level (1), so no press event fires at reset release.
- Input conditioning: all raw inputs pass SYNC_STAGES flops.
- Debounce: each key has a counter that restarts whenever the synchronized level differs from the accepted level. When the counter reaches DEBOUNCE_CYCLES, the accepted level updates.
- Press event: a one-cycle pulse on an accepted 1->0 transition. Releases generate no event. Holding a key yields exactly one event.
- States: LOAD_A, LOAD_B, LOAD_OP, ISSUE.
- LOAD_A + enter: op_a <= synchronized sw_data; next state LOAD_B.
- LOAD_B + enter: op_b <= sw_data; next state LOAD_OP.
- LOAD_OP + enter: op_sel <= sw_sel, cast directly (all 8 codes legal); alu_valid <= 1; next state ISSUE.
- Capture timing: the register update and state change take effect at the clock edge after the pulse cycle, so outputs are visible 1 cycle after the pulse.
- ISSUE handshake:
  - alu_valid stays high and op_a/op_b/op_sel stay frozen until a cycle with alu_valid & alu_ready.
  - On that edge: alu_valid <= 0, op_count <= op_count+1 (wraps 2^COUNT_W-1 -> 0), state <= LOAD_A.
  - alu_ready already high on entry gives a 1-cycle transfer.
  - alu_valid never depends combinationally on alu_ready.
- Cancel: in LOAD_B or LOAD_OP, state <= LOAD_A. Operand registers keep their values, but alu_valid is not asserted. In LOAD_A, cancel has no effect.
- ISSUE ignores both keys: no retraction once valid is raised.
- Simultaneous enter and cancel pulses in one cycle: cancel wins, with the same ISSUE exception.
- op_a/op_b/op_sel change only on the capture edges above; they are stable at all other times.
- Reset mid-transaction: alu_valid drops asynchronously and the entry is lost, with no partial update.

Decomposition:
- Shared package (alu_virtual_board_pkg) additions:
  - e_loader_state enum (LOAD_A, LOAD_B, LOAD_OP, ISSUE, 2 bits).
  - DEBOUNCE_DEFAULT constant.
  - Reuse of SELECT_W, ORIG_OPERAND_W and e_operation.
- Sub-module key_debounce: synchronizer, counter, accepted level and falling-edge pulse, parameterized by DEBOUNCE_CYCLES and SYNC_STAGES. Instantiated twice.
- FSM, operand registers and counter stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset/bounce: release reset with keys high, then toggle key_enter_n every 2 cycles for 20 cycles -> no event; state stays LOAD_A, stage_led=0001, all outputs 0.
- Full entry: sw_data=4'h9 + enter; sw_data=4'h5 + enter; sw_sel=3 + enter; alu_ready=1 -> op_a=9, op_b=5, op_sel=OP_ADD, alu_valid high exactly 1 cycle, op_count=1, state LOAD_A.
- Backpressure: same entry with alu_ready=0 for 10 cycles; press enter, cancel and change switches meanwhile -> alu_valid stays 1, outputs frozen at 9/5/OP_ADD; raise alu_ready -> single transfer.
- Cancel: load A=4'hF, enter B=4'h2, cancel in LOAD_OP -> state LOAD_A, alu_valid never 1, op_a=F, op_b=2 retained. Simultaneous enter+cancel in LOAD_B -> LOAD_A.
- Wrap: force 256 transactions with alu_ready=1 -> op_count goes 255 -> 0.
- Async reset: assert rst_n=0 mid-ISSUE between clock edges -> alu_valid=0 immediately, op_sel=OP_CLEAR, stage_led=0001.
